// File: rtl/mpe_pkg.sv
// Shared constants and feeder state encoding for the matrix PE operand path.
// Used by the feeder, matrix_pe and the bench.
package mpe_pkg;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 16;
  localparam int UOP_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/mpe_chan_reader.sv
// One operand channel: walks a RAM from a base line and streams the beats out
// over valid/ready, with a 2-entry FIFO absorbing the 1-cycle read latency.
module mpe_chan_reader
  import mpe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [UOP_W-1:0]  i_count,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_idle,
  output logic              o_last
);

  logic [UOP_W-1:0]  r_rdLeft;
  logic [UOP_W-1:0]  r_txLeft;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_count;

  logic              w_fifoEmpty;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_occupancy;

  // The returning read acts as the FIFO's front entry, so a beat can leave the
  // same cycle it arrives and back-to-back reads never leave a bubble.
  assign w_fifoEmpty = (r_count == 2'd0);
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign o_rd_en     = (r_rdLeft != '0) && (w_occupancy < 3'd2);
  assign o_rd_addr   = r_addr;
  assign o_valid     = !w_fifoEmpty || r_inflight;
  assign o_data      = !w_fifoEmpty ? r_fifo[r_rdPtr] : (r_inflight ? i_rd_data : '0);
  assign w_fire      = o_valid && i_ready;
  assign w_push      = r_inflight && !(w_fifoEmpty && i_ready);
  assign w_pop       = w_fire && !w_fifoEmpty;
  assign o_idle      = (r_txLeft == '0);
  assign o_last      = w_fire && (r_txLeft == UOP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdLeft   <= '0;
      r_txLeft   <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (i_start) begin
        r_rdLeft <= i_count;
        r_txLeft <= i_count;
        r_addr   <= i_base;
      end else begin
        if (o_rd_en) begin
          r_rdLeft <= r_rdLeft - UOP_W'(1);
          r_addr   <= r_addr + ADDR_W'(1);
        end
        if (w_fire) begin
          r_txLeft <= r_txLeft - UOP_W'(1);
        end
      end
      r_inflight <= o_rd_en;
      if (w_push) begin
        r_fifo[r_wrPtr] <= i_rd_data;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/mpe_stream_feeder.sv
// Memory-side transmitter for matrix_pe: issues one uop per command, then
// streams N neuron beats from NRAM and N weight beats from WRAM.
module mpe_stream_feeder
  import mpe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [UOP_W-1:0]  cmd_uop,
  input  logic [ADDR_W-1:0] cmd_nbase,
  input  logic [ADDR_W-1:0] cmd_wbase,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_rd_addr,
  input  logic [DATA_W-1:0] nram_rd_data,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_rd_addr,
  input  logic [DATA_W-1:0] wram_rd_data,
  output logic [UOP_W-1:0]  ib_ctl_uop,
  output logic              ib_ctl_uop_valid,
  input  logic              ib_ctl_uop_ready,
  output logic [DATA_W-1:0] nram_mpe_neuron,
  output logic              nram_mpe_neuron_valid,
  input  logic              nram_mpe_neuron_ready,
  output logic [DATA_W-1:0] wram_mpe_weight,
  output logic              wram_mpe_weight_valid,
  input  logic              wram_mpe_weight_ready,
  output logic              busy,
  output logic              done
);

  logic [1:0]        r_state;
  logic [UOP_W-1:0]  r_uop;
  logic [ADDR_W-1:0] r_nbase;
  logic [ADDR_W-1:0] r_wbase;

  logic w_uopFire;
  logic w_start;
  logic w_nIdle, w_nLast, w_wIdle, w_wLast;
  logic w_streamEnd;

  assign cmd_ready        = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign done             = (r_state == ST_DONE);
  assign ib_ctl_uop_valid = (r_state == ST_ISSUE);
  assign ib_ctl_uop       = r_uop;
  assign w_uopFire        = ib_ctl_uop_valid && ib_ctl_uop_ready;
  assign w_start          = w_uopFire && (r_uop != '0);
  // A channel counts as finished if it is already idle or is moving its last beat now.
  assign w_streamEnd      = (w_nIdle || w_nLast) && (w_wIdle || w_wLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_uop   <= '0;
      r_nbase <= '0;
      r_wbase <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_uop   <= cmd_uop;
            r_nbase <= cmd_nbase;
            r_wbase <= cmd_wbase;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_uopFire) begin
            r_state <= (r_uop == '0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_streamEnd) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mpe_chan_reader u_neuron (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_base    (r_nbase),
    .i_count   (r_uop),
    .o_rd_en   (nram_rd_en),
    .o_rd_addr (nram_rd_addr),
    .i_rd_data (nram_rd_data),
    .o_data    (nram_mpe_neuron),
    .o_valid   (nram_mpe_neuron_valid),
    .i_ready   (nram_mpe_neuron_ready),
    .o_idle    (w_nIdle),
    .o_last    (w_nLast)
  );

  mpe_chan_reader u_weight (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_base    (r_wbase),
    .i_count   (r_uop),
    .o_rd_en   (wram_rd_en),
    .o_rd_addr (wram_rd_addr),
    .i_rd_data (wram_rd_data),
    .o_data    (wram_mpe_weight),
    .o_valid   (wram_mpe_weight_valid),
    .i_ready   (wram_mpe_weight_ready),
    .o_idle    (w_wIdle),
    .o_last    (w_wLast)
  );

endmodule

// File: tb/tb_mpe_stream_feeder.sv
// Directed and randomized-ready bench for mpe_stream_feeder with RAM models
// and a scoreboard of expected uops and beats per channel.
module tb_mpe_stream_feeder;
  import mpe_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [UOP_W-1:0]  cmd_uop = '0;
  logic [ADDR_W-1:0] cmd_nbase = '0;
  logic [ADDR_W-1:0] cmd_wbase = '0;
  logic              nram_rd_en, wram_rd_en;
  logic [ADDR_W-1:0] nram_rd_addr, wram_rd_addr;
  logic [DATA_W-1:0] nram_rd_data = '0;
  logic [DATA_W-1:0] wram_rd_data = '0;
  logic [UOP_W-1:0]  ib_ctl_uop;
  logic              ib_ctl_uop_valid, ib_ctl_uop_ready;
  logic [DATA_W-1:0] nram_mpe_neuron, wram_mpe_weight;
  logic              nram_mpe_neuron_valid, nram_mpe_neuron_ready;
  logic              wram_mpe_weight_valid, wram_mpe_weight_ready;
  logic              busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [DATA_W-1:0] nQ[$];
  logic [DATA_W-1:0] wQ[$];
  logic [UOP_W-1:0]  uQ[$];
  logic [ADDR_W-1:0] nAddrLog[$];

  logic randMode = 1'b0;
  logic rN = 1'b1, rW = 1'b1, rU = 1'b1;
  logic nReadyCtl = 1'b1, wReadyCtl = 1'b1, uReadyCtl = 1'b1;

  int acceptCyc, uValidRiseCyc, hCyc, doneCyc, doneCnt, uopHsCnt;
  int nBeatCnt, wBeatCnt, nFirstCyc, nLastCyc, wFirstCyc, wLastCyc;
  int nRdCnt, wRdCnt, nValidCnt, wValidCnt;
  logic prevUValid, prevUReady, prevNValid, prevNReady, prevWValid, prevWReady;

  assign nram_mpe_neuron_ready = randMode ? rN : nReadyCtl;
  assign wram_mpe_weight_ready = randMode ? rW : wReadyCtl;
  assign ib_ctl_uop_ready      = randMode ? rU : uReadyCtl;

  mpe_stream_feeder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_uop               (cmd_uop),
    .cmd_nbase             (cmd_nbase),
    .cmd_wbase             (cmd_wbase),
    .nram_rd_en            (nram_rd_en),
    .nram_rd_addr          (nram_rd_addr),
    .nram_rd_data          (nram_rd_data),
    .wram_rd_en            (wram_rd_en),
    .wram_rd_addr          (wram_rd_addr),
    .wram_rd_data          (wram_rd_data),
    .ib_ctl_uop            (ib_ctl_uop),
    .ib_ctl_uop_valid      (ib_ctl_uop_valid),
    .ib_ctl_uop_ready      (ib_ctl_uop_ready),
    .nram_mpe_neuron       (nram_mpe_neuron),
    .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
    .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
    .wram_mpe_weight       (wram_mpe_weight),
    .wram_mpe_weight_valid (wram_mpe_weight_valid),
    .wram_mpe_weight_ready (wram_mpe_weight_ready),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] nData(input logic [ADDR_W-1:0] a);
    return {16{a, ~a}};
  endfunction

  function automatic logic [DATA_W-1:0] wData(input logic [ADDR_W-1:0] a);
    return {16{a ^ 16'h3C5A, a}};
  endfunction

  // Synchronous RAMs: data for a strobed address appears on the next cycle.
  always @(posedge clk) begin
    if (nram_rd_en) nram_rd_data <= nData(nram_rd_addr);
    if (wram_rd_en) wram_rd_data <= wData(wram_rd_addr);
  end

  // Random readies change just after the active edge.
  always @(posedge clk) begin
    #1;
    rN = 1'($urandom_range(0, 1));
    rW = 1'($urandom_range(0, 1));
    rU = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, compares against the scoreboard heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prevUValid && !prevUReady) checkOutput("uop_valid_hold", ib_ctl_uop_valid, 1);
      if (prevNValid && !prevNReady) checkOutput("n_valid_hold", nram_mpe_neuron_valid, 1);
      if (prevWValid && !prevWReady) checkOutput("w_valid_hold", wram_mpe_weight_valid, 1);
      if (ib_ctl_uop_valid && !prevUValid) uValidRiseCyc = cyc;
      if (ib_ctl_uop_valid) begin
        checkOutput("uop_sb_nonempty", uQ.size() != 0, 1);
        if (uQ.size() != 0) checkOutput("uop_value", ib_ctl_uop, uQ[0]);
        if (ib_ctl_uop_ready) begin
          uopHsCnt++;
          hCyc = cyc;
          if (uQ.size() != 0) void'(uQ.pop_front());
        end
      end
      if (nram_mpe_neuron_valid) begin
        nValidCnt++;
        checkOutput("n_sb_nonempty", nQ.size() != 0, 1);
        if (nQ.size() != 0) checkOutput("n_beat", nram_mpe_neuron, nQ[0]);
        if (nram_mpe_neuron_ready) begin
          if (nBeatCnt == 0) nFirstCyc = cyc;
          nLastCyc = cyc;
          nBeatCnt++;
          if (nQ.size() != 0) void'(nQ.pop_front());
        end
      end
      if (wram_mpe_weight_valid) begin
        wValidCnt++;
        checkOutput("w_sb_nonempty", wQ.size() != 0, 1);
        if (wQ.size() != 0) checkOutput("w_beat", wram_mpe_weight, wQ[0]);
        if (wram_mpe_weight_ready) begin
          if (wBeatCnt == 0) wFirstCyc = cyc;
          wLastCyc = cyc;
          wBeatCnt++;
          if (wQ.size() != 0) void'(wQ.pop_front());
        end
      end
      if (nram_rd_en) begin
        nRdCnt++;
        nAddrLog.push_back(nram_rd_addr);
      end
      if (wram_rd_en) wRdCnt++;
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      prevUValid = ib_ctl_uop_valid;
      prevUReady = ib_ctl_uop_ready;
      prevNValid = nram_mpe_neuron_valid;
      prevNReady = nram_mpe_neuron_ready;
      prevWValid = wram_mpe_weight_valid;
      prevWReady = wram_mpe_weight_ready;
    end else begin
      prevUValid = 1'b0; prevUReady = 1'b0;
      prevNValid = 1'b0; prevNReady = 1'b0;
      prevWValid = 1'b0; prevWReady = 1'b0;
    end
  end

  // Waits for an idle feeder, presents one command and loads the scoreboard.
  task automatic applyStimulus(input logic [UOP_W-1:0] uop, input logic [ADDR_W-1:0] nb,
                               input logic [ADDR_W-1:0] wb);
    int waitCyc = 0;
    logic [ADDR_W-1:0] a;
    @(posedge clk); #1;
    while (!cmd_ready && waitCyc < 2000) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput("cmd_ready_wait", waitCyc < 2000, 1);
    nBeatCnt = 0; wBeatCnt = 0; nRdCnt = 0; wRdCnt = 0;
    nValidCnt = 0; wValidCnt = 0; uopHsCnt = 0;
    nAddrLog.delete();
    cmd_valid = 1'b1; cmd_uop = uop; cmd_nbase = nb; cmd_wbase = wb;
    acceptCyc = cyc;
    uQ.push_back(uop);
    for (int i = 0; i < int'(uop); i++) begin
      a = nb + ADDR_W'(i);
      nQ.push_back(nData(a));
      a = wb + ADDR_W'(i);
      wQ.push_back(wData(a));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("done_wait", doneCnt >= target, 1);
  endtask

  task automatic checkResetValues(input string phase);
    $display("[TB] reset value checks: %s", phase);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_uop_valid", ib_ctl_uop_valid, 0);
    checkOutput("rst_n_valid", nram_mpe_neuron_valid, 0);
    checkOutput("rst_w_valid", wram_mpe_weight_valid, 0);
    checkOutput("rst_nram_rd_en", nram_rd_en, 0);
    checkOutput("rst_wram_rd_en", wram_rd_en, 0);
    checkOutput("rst_uop", ib_ctl_uop, 0);
    checkOutput("rst_neuron", nram_mpe_neuron, 0);
    checkOutput("rst_weight", wram_mpe_weight, 0);
    checkOutput("rst_nram_addr", nram_rd_addr, 0);
    checkOutput("rst_wram_addr", wram_rd_addr, 0);
  endtask

  initial begin
    int target;
    int n;
    doneCnt = 0; uopHsCnt = 0; nBeatCnt = 0; wBeatCnt = 0;

    // Power-on reset
    repeat (3) @(negedge clk);
    checkResetValues("power-on");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single command, ready held high
    $display("[TB] single command N=35");
    target = doneCnt + 1;
    applyStimulus(8'h23, 16'h0000, 16'h0000);
    waitDone(target, 200);
    checkOutput("uop_valid_latency", uValidRiseCyc, acceptCyc + 1);
    checkOutput("uop_sent_once", uopHsCnt, 1);
    checkOutput("n_first_beat", nFirstCyc, hCyc + 2);
    checkOutput("n_last_beat", nLastCyc, hCyc + 36);
    checkOutput("w_first_beat", wFirstCyc, hCyc + 2);
    checkOutput("w_last_beat", wLastCyc, hCyc + 36);
    checkOutput("n_beat_count", nBeatCnt, 35);
    checkOutput("w_beat_count", wBeatCnt, 35);
    checkOutput("done_timing", doneCyc, hCyc + 37);
    checkOutput("busy_in_done", busy, 1);
    checkOutput("cmd_ready_in_done", cmd_ready, 0);
    @(posedge clk); #1;
    checkOutput("cmd_ready_after_done", cmd_ready, 1);
    checkOutput("done_pulse_width", done, 0);

    // Randomized readies over 140 consecutive lines
    $display("[TB] randomized ready, 4 commands");
    randMode = 1'b1;
    target = doneCnt + 4;
    for (int c = 0; c < 4; c++) applyStimulus(8'd35, ADDR_W'(35 * c), ADDR_W'(35 * c));
    waitDone(target, 3000);
    checkOutput("rand_done_count", doneCnt, target);
    checkOutput("rand_n_sb_drained", nQ.size(), 0);
    checkOutput("rand_w_sb_drained", wQ.size(), 0);
    @(posedge clk); #1;
    randMode = 1'b0;

    // Weight channel stalled while neuron runs
    $display("[TB] asymmetric stall N=8");
    wReadyCtl = 1'b0;
    target = doneCnt + 1;
    applyStimulus(8'd8, 16'h0100, 16'h0200);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stall_n_beats", nBeatCnt, 8);
    checkOutput("stall_w_beats", wBeatCnt, 0);
    checkOutput("stall_w_reads", wRdCnt, 2);
    checkOutput("stall_no_done", doneCnt, target - 1);
    wReadyCtl = 1'b1;
    waitDone(target, 100);
    checkOutput("n_before_w", nLastCyc < wLastCyc, 1);
    checkOutput("stall_w_beats_final", wBeatCnt, 8);
    checkOutput("stall_w_reads_final", wRdCnt, 8);
    checkOutput("stall_done_timing", doneCyc, wLastCyc + 1);

    // Zero-length command
    $display("[TB] zero length");
    target = doneCnt + 1;
    applyStimulus(8'd0, 16'h0300, 16'h0300);
    waitDone(target, 50);
    checkOutput("zero_done_timing", doneCyc, hCyc + 1);
    checkOutput("zero_n_reads", nRdCnt, 0);
    checkOutput("zero_w_reads", wRdCnt, 0);
    checkOutput("zero_n_valids", nValidCnt, 0);
    checkOutput("zero_w_valids", wValidCnt, 0);

    // Address wrap across the top of NRAM
    $display("[TB] address wrap");
    target = doneCnt + 1;
    applyStimulus(8'd4, 16'hFFFE, 16'h0010);
    waitDone(target, 100);
    checkOutput("wrap_addr_count", nAddrLog.size(), 4);
    if (nAddrLog.size() == 4) begin
      checkOutput("wrap_addr0", nAddrLog[0], 16'hFFFE);
      checkOutput("wrap_addr1", nAddrLog[1], 16'hFFFF);
      checkOutput("wrap_addr2", nAddrLog[2], 16'h0000);
      checkOutput("wrap_addr3", nAddrLog[3], 16'h0001);
    end
    checkOutput("wrap_n_beats", nBeatCnt, 4);

    // Reset in the middle of a 10-beat command
    $display("[TB] reset mid-stream");
    applyStimulus(8'd10, 16'h0400, 16'h0500);
    n = 0;
    while (nBeatCnt < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mid_reset_reached", nBeatCnt >= 3, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid-stream");
    nQ.delete(); wQ.delete(); uQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("held");
    rst_n = 1'b1;
    target = doneCnt + 1;
    applyStimulus(8'd2, 16'h0600, 16'h0700);
    waitDone(target, 100);
    checkOutput("post_reset_n_beats", nBeatCnt, 2);
    checkOutput("post_reset_w_beats", wBeatCnt, 2);
    checkOutput("post_reset_n_reads", nRdCnt, 2);

    repeat (3) @(posedge clk);
    checkOutput("final_n_sb_empty", nQ.size(), 0);
    checkOutput("final_w_sb_empty", wQ.size(), 0);
    checkOutput("final_uop_sb_empty", uQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
